// File: rtl/tlb_lookup_arbiter.sv
// rtl/tlb_lookup_arbiter.sv - shares one TLB port between fetch, data, probe and write requesters
module tlb_lookup_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [31:0] i_vaddr,
  output logic        i_ack,
  output logic [31:0] i_paddr,
  output logic        i_miss,
  output logic        i_invalid,
  output logic        i_uncached,
  input  logic        d_req,
  input  logic [31:0] d_vaddr,
  input  logic        d_we,
  output logic        d_ack,
  output logic [31:0] d_paddr,
  output logic        d_miss,
  output logic        d_invalid,
  output logic        d_modified,
  output logic        d_uncached,
  input  logic        p_req,
  input  logic [31:0] p_vaddr,
  output logic        p_ack,
  output logic        p_miss,
  output logic [2:0]  p_index,
  input  logic        w_req,
  input  logic        w_random,
  output logic        w_ack,
  output logic [31:0] tlb_vaddr,
  output logic        tlb_tlbwi,
  output logic        tlb_tlbwr,
  input  logic [31:0] tlb_paddr,
  input  logic        tlb_miss,
  input  logic        tlb_valid,
  input  logic        tlb_dirty,
  input  logic        tlb_uncached,
  input  logic [2:0]  tlb_matched_index
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_LOOKUP = 2'd1;
  localparam logic [1:0] ST_WRITE  = 2'd2;
  localparam logic [1:0] ST_RESP   = 2'd3;

  localparam logic [1:0] SRC_I = 2'd0;
  localparam logic [1:0] SRC_D = 2'd1;
  localparam logic [1:0] SRC_P = 2'd2;
  localparam logic [1:0] SRC_W = 2'd3;

  localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

  logic [1:0]       state;
  logic [1:0]       src_q;
  logic [31:0]      addr_q;
  logic             we_q;
  logic [CNT_W-1:0] starve_cnt;

  logic             grant_any;
  logic [1:0]       grant_src;
  logic             i_forced;

  logic             bypass;
  logic [31:0]      r_paddr;
  logic             r_miss;
  logic             r_invalid;
  logic             r_modified;
  logic             r_uncached;

  // Fixed priority w > p > d > i, except a starved fetch jumps ahead of data.
  always_comb begin
    grant_any = 1'b1;
    grant_src = SRC_I;
    i_forced  = i_req && (starve_cnt == STARVE_MAX);
    if (w_req)
      grant_src = SRC_W;
    else if (p_req)
      grant_src = SRC_P;
    else if (d_req && !i_forced)
      grant_src = SRC_D;
    else if (i_req)
      grant_src = SRC_I;
    else
      grant_any = 1'b0;
  end

  // kseg0/kseg1 fetch and data accesses never touch the TLB; probes always do.
  always_comb begin
    bypass     = (src_q == SRC_I || src_q == SRC_D) && (addr_q[31:30] == 2'b10);
    r_paddr    = bypass ? {3'b000, addr_q[28:0]} : tlb_paddr;
    r_uncached = bypass ? addr_q[29] : tlb_uncached;
    r_miss     = !bypass && tlb_miss;
    r_invalid  = !bypass && !tlb_miss && !tlb_valid;
    r_modified = !bypass && we_q && !tlb_miss && tlb_valid && !tlb_dirty;
  end

  assign tlb_vaddr = (state == ST_LOOKUP && !bypass) ? addr_q : 32'h0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      src_q     <= SRC_I;
      addr_q    <= 32'h0;
      we_q      <= 1'b0;
      i_ack     <= 1'b0;
      d_ack     <= 1'b0;
      p_ack     <= 1'b0;
      w_ack     <= 1'b0;
      tlb_tlbwi <= 1'b0;
      tlb_tlbwr <= 1'b0;
    end else begin
      i_ack     <= 1'b0;
      d_ack     <= 1'b0;
      p_ack     <= 1'b0;
      w_ack     <= 1'b0;
      tlb_tlbwi <= 1'b0;
      tlb_tlbwr <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (grant_any) begin
            src_q <= grant_src;
            case (grant_src)
              SRC_W: begin
                state     <= ST_WRITE;
                tlb_tlbwr <= w_random;
                tlb_tlbwi <= !w_random;
              end
              SRC_P: begin
                state  <= ST_LOOKUP;
                addr_q <= p_vaddr;
                we_q   <= 1'b0;
              end
              SRC_D: begin
                state  <= ST_LOOKUP;
                addr_q <= d_vaddr;
                we_q   <= d_we;
              end
              SRC_I: begin
                state  <= ST_LOOKUP;
                addr_q <= i_vaddr;
                we_q   <= 1'b0;
              end
            endcase
          end
        end
        ST_LOOKUP: begin
          state <= ST_RESP;
          i_ack <= (src_q == SRC_I);
          d_ack <= (src_q == SRC_D);
          p_ack <= (src_q == SRC_P);
        end
        ST_WRITE: begin
          // The TLB commits on this edge, so any later lookup sees the new entry.
          state <= ST_RESP;
          w_ack <= 1'b1;
        end
        ST_RESP: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_cnt <= '0;
    end else if (state == ST_IDLE) begin
      if (!i_req || (grant_any && grant_src == SRC_I))
        starve_cnt <= '0;
      else if (grant_any && grant_src == SRC_D && starve_cnt != STARVE_MAX)
        starve_cnt <= starve_cnt + CNT_W'(1);
    end
  end

  // Each requester's results hold until its own next lookup completes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      i_paddr    <= 32'h0;
      i_miss     <= 1'b0;
      i_invalid  <= 1'b0;
      i_uncached <= 1'b0;
      d_paddr    <= 32'h0;
      d_miss     <= 1'b0;
      d_invalid  <= 1'b0;
      d_modified <= 1'b0;
      d_uncached <= 1'b0;
      p_miss     <= 1'b0;
      p_index    <= 3'd0;
    end else if (state == ST_LOOKUP) begin
      case (src_q)
        SRC_I: begin
          i_paddr    <= r_paddr;
          i_miss     <= r_miss;
          i_invalid  <= r_invalid;
          i_uncached <= r_uncached;
        end
        SRC_D: begin
          d_paddr    <= r_paddr;
          d_miss     <= r_miss;
          d_invalid  <= r_invalid;
          d_modified <= r_modified;
          d_uncached <= r_uncached;
        end
        SRC_P: begin
          p_miss  <= tlb_miss;
          p_index <= tlb_miss ? 3'd0 : tlb_matched_index;
        end
        default: begin
        end
      endcase
    end
  end

endmodule
